// File: rtl/microsequencer_if.sv
// Microstore / datapath-facing bundle of the microsequencer.
// The sequencer connects through the slave modport; the microstore/stimulus side uses master.
interface microsequencer_if #(
    parameter int ADDR_W      = 6,
    parameter int CTRL_W      = 32,
    parameter int NCOND       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SEL_W = $clog2(NCOND);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    logic [NCOND-1:0]  cond;
    logic [ADDR_W-1:0] map_addr;
    logic [ADDR_W-1:0] uaddr;
    logic [2:0]        next_op;
    logic [SEL_W-1:0]  cond_sel;
    logic              cond_inv;
    logic [ADDR_W-1:0] cr;
    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] state;
    logic [SP_W-1:0]   sp;
    logic              stack_err;

    modport slave (
        input  cond, map_addr, next_op, cond_sel, cond_inv, cr, ctrl_in,
        output uaddr, ctrl, state, sp, stack_err
    );

    modport master (
        output cond, map_addr, next_op, cond_sel, cond_inv, cr, ctrl_in,
        input  uaddr, ctrl, state, sp, stack_err
    );
endinterface

// File: rtl/microsequencer.sv
// Microprogram sequencer: micro-PC, next-address select, return stack for CALL/RET,
// and the registered control word presented to the datapath.
module microsequencer #(
    parameter int ADDR_W      = 6,
    parameter int CTRL_W      = 32,
    parameter int NCOND       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    microsequencer_if.slave   bus
);
    // op   | meaning
    // INC  | uaddr+1
    // JMP  | cr
    // MAP  | map_addr
    // CJMP | c ? cr : uaddr+1
    // CWAIT| c ? uaddr+1 : hold
    // CALL | push uaddr+1, go to cr
    // RET  | pop, go to popped address (0 when empty)
    // CMAP | c ? map_addr : uaddr+1
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_MAP   = 3'b010;
    localparam logic [2:0] OP_CJMP  = 3'b011;
    localparam logic [2:0] OP_CWAIT = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_RET   = 3'b110;
    localparam logic [2:0] OP_CMAP  = 3'b111;

    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [ADDR_W-1:0] state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_q, stack_d;

    logic              c;
    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] pop_addr;

    always_ff @(posedge clk) begin
        if (clr) begin
            upc_q   <= '0;
            state_q <= '0;
            ctrl_q  <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            stack_q <= '0;
        end else begin
            upc_q   <= upc_d;
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    always_comb begin
        c        = bus.cond[bus.cond_sel] ^ bus.cond_inv;
        upc_inc  = upc_q + ADDR_W'(1);
        pop_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) pop_addr = stack_q[i];
        end

        upc_d   = upc_inc;
        state_d = upc_q;
        ctrl_d  = bus.ctrl_in;
        sp_d    = sp_q;
        err_d   = err_q;
        stack_d = stack_q;

        case (bus.next_op)
            OP_JMP:   upc_d = bus.cr;
            OP_MAP:   upc_d = bus.map_addr;
            OP_CJMP:  upc_d = c ? bus.cr : upc_inc;
            OP_CWAIT: upc_d = c ? upc_inc : upc_q;
            OP_CMAP:  upc_d = c ? bus.map_addr : upc_inc;
            OP_CALL: begin
                // a full stack still takes the jump; only the return address is lost
                upc_d = bus.cr;
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (sp_q == SP_W'(i)) stack_d[i] = upc_inc;
                    end
                    sp_d = sp_q + SP_W'(1);
                end
            end
            OP_RET: begin
                if (sp_q == '0) begin
                    upc_d = '0;
                    err_d = 1'b1;
                end else begin
                    upc_d = pop_addr;
                    sp_d  = sp_q - SP_W'(1);
                end
            end
            default:  upc_d = upc_inc;
        endcase
    end

    always_comb begin
        bus.uaddr     = upc_q;
        bus.ctrl      = ctrl_q;
        bus.state     = state_q;
        bus.sp        = sp_q;
        bus.stack_err = err_q;
    end
endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based behavioural model.
module tb_microsequencer;
    localparam int ADDR_W = 6;
    localparam int CTRL_W = 32;
    localparam int NCOND  = 8;
    localparam int DEPTH  = 4;
    localparam int AMOD   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    microsequencer_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NCOND(NCOND), .STACK_DEPTH(DEPTH)) bus();

    microsequencer #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NCOND(NCOND), .STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // behavioural model
    int          m_upc, m_state;
    logic [31:0] m_ctrl;
    bit          m_err;
    bit          m_valid = 1'b0;
    int          m_stk[$];

    always @(posedge clk) begin
        int nxt;
        int inc;
        bit cc;
        if (clr) begin
            m_upc = 0; m_state = 0; m_ctrl = 0; m_err = 0; m_valid = 1;
            m_stk.delete();
        end else if (m_valid) begin
            cc  = bus.cond[bus.cond_sel] ^ bus.cond_inv;
            inc = (m_upc + 1) % AMOD;
            case (bus.next_op)
                3'd0: nxt = inc;
                3'd1: nxt = int'(bus.cr);
                3'd2: nxt = int'(bus.map_addr);
                3'd3: nxt = cc ? int'(bus.cr) : inc;
                3'd4: nxt = cc ? inc : m_upc;
                3'd5: begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(inc);
                    else m_err = 1;
                    nxt = int'(bus.cr);
                end
                3'd6: begin
                    if (m_stk.size() == 0) begin nxt = 0; m_err = 1; end
                    else nxt = m_stk.pop_back();
                end
                default: nxt = cc ? int'(bus.map_addr) : inc;
            endcase
            m_state = m_upc;
            m_ctrl  = bus.ctrl_in;
            m_upc   = nxt;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_uaddr", 64'(bus.uaddr), 64'(m_upc));
            chk("m_ctrl",  64'(bus.ctrl),  64'(m_ctrl));
            chk("m_state", 64'(bus.state), 64'(m_state));
            chk("m_sp",    64'(bus.sp),    64'(m_stk.size()));
            chk("m_err",   64'(bus.stack_err), 64'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] o, input logic [5:0] tcr);
        bus.next_op = o;
        bus.cr      = tcr;
        bus.ctrl_in = $urandom;
        tick();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_uaddr"}, 64'(bus.uaddr), 64'd0);
        chk({name, "_ctrl"},  64'(bus.ctrl),  64'd0);
        chk({name, "_state"}, 64'(bus.state), 64'd0);
        chk({name, "_sp"},    64'(bus.sp),    64'd0);
        chk({name, "_err"},   64'(bus.stack_err), 64'd0);
    endtask

    initial begin
        bus.cond = 8'hFF; bus.map_addr = 6'd33; bus.next_op = 3'd5; bus.cond_sel = 3'd2;
        bus.cond_inv = 1'b0; bus.cr = 6'd17; bus.ctrl_in = 32'hDEADBEEF;
        clr = 1'b1;
        tick(); tick();
        chk_zero("reset");
        clr = 1'b0;

        // INC wrap and ctrl/state alignment
        bus.cond = 8'h01; bus.cond_sel = 3'd0;
        op(3'd1, 6'd62);
        chk("jmp62", 64'(bus.uaddr), 64'd62);
        op(3'd0, 6'd0);
        chk("inc63", 64'(bus.uaddr), 64'd63);
        bus.next_op = 3'd0; bus.ctrl_in = 32'hA5A5A5A5;
        tick();
        chk("wrap0", 64'(bus.uaddr), 64'd0);
        chk("wrap_ctrl", 64'(bus.ctrl), 64'hA5A5A5A5);
        chk("wrap_state", 64'(bus.state), 64'd63);

        // CWAIT on cond[3], both polarities
        for (int pol = 0; pol < 2; pol++) begin
            op(3'd1, 6'd10);
            bus.cond_sel = 3'd3; bus.cond_inv = pol[0];
            bus.cond = (pol == 0) ? 8'h01 : 8'h09;
            for (int k = 0; k < 3; k++) begin
                op(3'd4, 6'd0);
                chk("cwait_hold", 64'(bus.uaddr), 64'd10);
            end
            bus.cond = (pol == 0) ? 8'h09 : 8'h01;
            op(3'd4, 6'd0);
            chk("cwait_go", 64'(bus.uaddr), 64'd11);
        end

        // CJMP / CMAP, c=1 then c=0 (cond[0] is constant 1)
        bus.cond = 8'h01; bus.cond_sel = 3'd0; bus.cond_inv = 1'b0; bus.map_addr = 6'd20;
        op(3'd3, 6'd40);
        chk("cjmp_t", 64'(bus.uaddr), 64'd40);
        op(3'd7, 6'd40);
        chk("cmap_t", 64'(bus.uaddr), 64'd20);
        bus.cond_inv = 1'b1;
        op(3'd3, 6'd40);
        chk("cjmp_f", 64'(bus.uaddr), 64'd21);
        op(3'd7, 6'd40);
        chk("cmap_f", 64'(bus.uaddr), 64'd22);
        bus.cond_inv = 1'b0;

        // nested CALL/RET
        op(3'd1, 6'd5);
        op(3'd5, 6'd30);
        chk("call1", 64'(bus.uaddr), 64'd30);
        op(3'd5, 6'd50);
        chk("call2", 64'(bus.uaddr), 64'd50);
        chk("call2_sp", 64'(bus.sp), 64'd2);
        op(3'd6, 6'd0);
        chk("ret1", 64'(bus.uaddr), 64'd31);
        op(3'd6, 6'd0);
        chk("ret2", 64'(bus.uaddr), 64'd6);
        chk("ret2_sp", 64'(bus.sp), 64'd0);
        chk("ret2_err", 64'(bus.stack_err), 64'd0);

        // overflow
        for (int k = 0; k < 4; k++) op(3'd5, 6'd7);
        chk("full_sp", 64'(bus.sp), 64'd4);
        chk("full_err", 64'(bus.stack_err), 64'd0);
        op(3'd5, 6'd44);
        chk("ovf_uaddr", 64'(bus.uaddr), 64'd44);
        chk("ovf_sp", 64'(bus.sp), 64'd4);
        chk("ovf_err", 64'(bus.stack_err), 64'd1);
        op(3'd6, 6'd0);
        chk("ovf_ret", 64'(bus.uaddr), 64'd8);

        // reset mid-CALL chain, then underflow
        clr = 1'b1; tick(); clr = 1'b0;
        op(3'd5, 6'd12);
        op(3'd5, 6'd13);
        chk("chain_sp", 64'(bus.sp), 64'd2);
        clr = 1'b1;
        op(3'd5, 6'd14);
        chk_zero("midcall");
        clr = 1'b0;
        op(3'd6, 6'd0);
        chk("unf_uaddr", 64'(bus.uaddr), 64'd0);
        chk("unf_sp", 64'(bus.sp), 64'd0);
        chk("unf_err", 64'(bus.stack_err), 64'd1);
        op(3'd0, 6'd0);
        chk("err_sticky", 64'(bus.stack_err), 64'd1);

        // randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            clr          = ($urandom_range(63) == 0);
            bus.next_op  = 3'($urandom_range(7));
            bus.cond_sel = 3'($urandom_range(7));
            bus.cond_inv = 1'($urandom_range(1));
            bus.cond     = {7'($urandom_range(127)), 1'b1};
            bus.cr       = 6'($urandom_range(63));
            bus.map_addr = 6'($urandom_range(63));
            bus.ctrl_in  = $urandom;
            tick();
        end
        clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/microsequencer.md
# microsequencer

Parametrised microprogram sequencer for the SPARC datapath control path: it holds the micro-PC, presents it to an external asynchronous microstore, selects the next address, and registers the returned control word for the datapath. It generalises the fixed 5-bit, four-source next-state logic with:
- configurable address, control-word and condition widths;
- polarity-selectable condition testing;
- a hardware return stack for microsubroutine CALL/RET.

## Interface
Parameters:
- ADDR_W, 6, micro-address width (microstore depth 2^ADDR_W)
- CTRL_W, 32, control-word width driven to the datapath
- NCOND, 8, number of condition inputs (power of two, ≥2)
- STACK_DEPTH, 4, return-stack entries (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- clr  in  1  synchronous active-high reset
- cond  in  NCOND  condition inputs (MOC, instr[13], branch cond, flags, constant 1 on bit 0)
- map_addr  in  ADDR_W  opcode-decoder entry address
- uaddr  out  ADDR_W  current micro-PC, addresses the microstore
- next_op  in  3  sequencing op of microword at uaddr
- cond_sel  in  clog2(NCOND)  condition select
- cond_inv  in  1  invert selected condition
- cr  in  ADDR_W  branch/call target field
- ctrl_in  in  CTRL_W  control field of microword at uaddr
- ctrl  out  CTRL_W  registered control word
- state  out  ADDR_W  address whose control word is on ctrl
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy
- stack_err  out  1  sticky overflow/underflow flag

## Operation
- c = cond[cond_sel] XOR cond_inv, evaluated combinationally in the cycle uaddr is presented.
- Next address by next_op:
  - 000 INC: uaddr+1
  - 001 JMP: cr
  - 010 MAP: map_addr
  - 011 CJMP: c ? cr : uaddr+1
  - 100 CWAIT: c ? uaddr+1 : uaddr (hold)
  - 101 CALL: push uaddr+1, go to cr
  - 110 RET: pop, go to popped address
  - 111 CMAP: c ? map_addr : uaddr+1
- uaddr+1 is modulo 2^ADDR_W; all-ones wraps to 0.
- Stack is LIFO and sp counts entries 0..STACK_DEPTH.
- CALL with sp==STACK_DEPTH: no push, jump to cr still taken, stack_err set.
- RET with sp==0: next address 0, sp stays 0, stack_err set.
- stack_err is cleared only by clr.
- Datapath control lives only in ctrl_in; next_op has no datapath side effects.

## Timing
- On every rising edge with clr=0:
  - uaddr ← next address
  - ctrl ← ctrl_in
  - state ← uaddr (old value)
  - stack/sp update
- ctrl and state are aligned: one cycle after the address is presented.
- Condition sampling for a microword precedes assertion of its own ctrl by one cycle. Microcode must account for this; e.g. a CWAIT on MOC keeps ctrl steady while waiting.
- Reset (clr=1 at edge), which has priority over all ops, including mid-CALL or mid-wait:
  - uaddr = 0, ctrl = 0, state = 0
  - sp = 0, stack contents discarded
  - stack_err = 0
- First cycle after reset presents address 0.
- Stack entries are registers. Push and pop complete in one edge, so back-to-back CALL/RET in consecutive cycles must work.
- No combinational path from ctrl_in to any output.

## Test plan
- Reset: hold clr 2 cycles with junk inputs → uaddr=0, ctrl=0, state=0, sp=0, stack_err=0. Assert clr mid-CALL chain at sp=2 → all zero next cycle.
- INC wrap, ADDR_W=6: start at 62 with next_op=INC → uaddr 63, then 0. ctrl_in=0xA5A5A5A5 at address 63 appears on ctrl with state=63 one cycle later.
- CWAIT on cond[3], cond_inv=0, cond[3] low for 3 cycles at address 10 → uaddr stays 10 for 3 cycles, then 11 the cycle after cond[3] rises. Repeat with cond_inv=1 → inverse behaviour.
- CJMP/CMAP with cr=40, map_addr=20:
  - c=1 → 40 and 20 respectively
  - c=0 → uaddr+1
- Nested calls at address 5 and target 30:
  - CALL 30, then at 30 CALL 50 → sp=2
  - RET at 50 → 31
  - RET → 6, sp=0
  - stack_err stays 0
- Overflow and underflow, STACK_DEPTH=4:
  - Fifth consecutive CALL → jump to cr taken, sp stays 4, stack_err=1.
  - After clr, RET at sp=0 → uaddr=0, stack_err=1.
